// File: rtl/keypad_matrix_model.sv
// ============================================================================
// Module   : keypad_matrix_model
// Purpose  : Responder-side model of a 4x4 keypad button matrix with optional
//            contact bounce (enabled by defining KEYPAD_BOUNCE_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module keypad_matrix_model #(
  parameter int         BOUNCE_CYCLES = 64,
  parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] r_sel,
  input  logic [3:0] key_code,
  input  logic       press_req,
  input  logic       release_req,
  output logic [3:0] col,
  output logic       busy,
  output logic       held
);

  typedef enum logic [1:0] {
    ST_IDLE           = 2'd0,
    ST_PRESS_BOUNCE   = 2'd1,
    ST_HELD           = 2'd2,
    ST_RELEASE_BOUNCE = 2'd3
  } state_t;

  state_t     state_q;
  logic       contact_q;
  logic [3:0] key_q;
  logic       held_q;

`ifdef KEYPAD_BOUNCE_EN
  localparam int               CNT_W    = $clog2(BOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BOUNCE_CYCLES - 1);
  // An all-zero seed would lock the LFSR, so it is nudged to 8'h01.
  localparam logic [7:0]       SEED     = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

  logic [CNT_W-1:0] count_q;
  logic [7:0]       lfsr_q;
  logic [7:0]       lfsr_d;
  logic             busy_q;

  // Fibonacci form of x^8 + x^6 + x^5 + x^4 + 1.
  assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      contact_q <= 1'b0;
      key_q     <= 4'h0;
      count_q   <= '0;
      busy_q    <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (press_req) begin
            key_q   <= key_code;
            count_q <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_PRESS_BOUNCE;
          end
        end
        ST_PRESS_BOUNCE: begin
          if (count_q == CNT_LAST) begin
            contact_q <= 1'b1;
            busy_q    <= 1'b0;
            held_q    <= 1'b1;
            state_q   <= ST_HELD;
          end else begin
            contact_q <= lfsr_q[0];
            count_q   <= count_q + 1'b1;
          end
        end
        ST_HELD: begin
          if (release_req) begin
            count_q <= '0;
            busy_q  <= 1'b1;
            held_q  <= 1'b0;
            state_q <= ST_RELEASE_BOUNCE;
          end
        end
        ST_RELEASE_BOUNCE: begin
          if (count_q == CNT_LAST) begin
            contact_q <= 1'b0;
            busy_q    <= 1'b0;
            state_q   <= ST_IDLE;
          end else begin
            contact_q <= lfsr_q[0];
            count_q   <= count_q + 1'b1;
          end
        end
        default: begin
          contact_q <= 1'b0;
          busy_q    <= 1'b0;
          held_q    <= 1'b0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^{LFSR_SEED, BOUNCE_CYCLES[7:0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      contact_q <= 1'b0;
      key_q     <= 4'h0;
      held_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (press_req) begin
            key_q     <= key_code;
            contact_q <= 1'b1;
            held_q    <= 1'b1;
            state_q   <= ST_HELD;
          end
        end
        ST_HELD: begin
          if (release_req) begin
            contact_q <= 1'b0;
            held_q    <= 1'b0;
            state_q   <= ST_IDLE;
          end
        end
        default: begin
          contact_q <= 1'b0;
          held_q    <= 1'b0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = 1'b0;
`endif

  assign held = held_q;

  // Only the held key's column reacts, however many rows are driven at once.
  always_comb begin
    col = 4'hF;
    if (contact_q && !r_sel[key_q[3:2]]) begin
      col[key_q[1:0]] = 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_keypad_matrix_model.sv
// ============================================================================
// Module   : tb_keypad_matrix_model
// Purpose  : Scoreboard bench for keypad_matrix_model (both KEYPAD_BOUNCE_EN
//            builds).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_keypad_matrix_model;

  localparam int BC = 64;
`ifdef KEYPAD_BOUNCE_EN
  localparam int WIN = BC;
`else
  localparam int WIN = 0;
`endif
  localparam int M_IDLE = 0;
  localparam int M_PB   = 1;
  localparam int M_HELD = 2;
  localparam int M_RB   = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] r_sel;
  logic [3:0] key_code;
  logic       press_req;
  logic       release_req;
  logic [3:0] col;
  logic       busy;
  logic       held;

  typedef struct packed {
    logic       held;
    logic [3:0] key;
  } exp_t;

  exp_t       sb[$];
  int         m_st;
  logic [3:0] m_key;
  int         n_tests = 0;
  int         n_fail  = 0;
  int         win_toggles;

  keypad_matrix_model #(
    .BOUNCE_CYCLES(BC),
    .LFSR_SEED    (8'hA5)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .r_sel      (r_sel),
    .key_code   (key_code),
    .press_req  (press_req),
    .release_req(release_req),
    .col        (col),
    .busy       (busy),
    .held       (held)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] model_col(input logic c, input logic [3:0] k,
                                           input logic [3:0] rs);
    logic [3:0] v;
    v = 4'hF;
    if (c && (rs[k[3:2]] == 1'b0)) v[k[1:0]] = 1'b0;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a one-cycle request; the model decides whether it is accepted.
  task automatic issue(input logic p, input logic r, input logic [3:0] k);
    exp_t e;
    press_req   = p;
    release_req = r;
    key_code    = k;
    if (m_st == M_IDLE && p) begin
      m_key  = k;
      m_st   = (WIN > 0) ? M_PB : M_HELD;
      e.held = 1'b1;
      e.key  = k;
      sb.push_back(e);
    end else if (m_st == M_HELD && r) begin
      m_st   = (WIN > 0) ? M_RB : M_IDLE;
      e.held = 1'b0;
      e.key  = m_key;
      sb.push_back(e);
    end
    tick();
    press_req   = 1'b0;
    release_req = 1'b0;
  endtask

  task automatic wait_window(input int n);
`ifdef KEYPAD_BOUNCE_EN
    int         bad;
    logic [3:0] prev;
    bad         = 0;
    prev        = col;
    win_toggles = 0;
    for (int i = 0; i < n; i++) begin
      if (busy !== 1'b1) bad++;
      if (col !== prev) win_toggles++;
      prev = col;
      tick();
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL busy_window: %0d cycles with busy=0, required 0 such cycles", bad);
    end
    if (m_st == M_PB) m_st = M_HELD;
    if (m_st == M_RB) m_st = M_IDLE;
`else
    for (int i = 0; i < n; i++) tick();
`endif
  endtask

  task automatic test_reset();
    reset       = 1'b0;
    r_sel       = 4'b0000;
    key_code    = 4'h0;
    press_req   = 1'b0;
    release_req = 1'b0;
    m_st        = M_IDLE;
    m_key       = 4'h0;
    repeat (3) tick();
    n_tests++;
    if (col !== 4'hF || busy !== 1'b0 || held !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: col=%b busy=%b held=%b, required col=1111 busy=0 held=0",
               col, busy, held);
    end
    @(negedge clk);
    reset = 1'b1;
    tick();
  endtask

  task automatic test_press();
    exp_t e;
    r_sel = 4'b1101;
    issue(1'b1, 1'b0, 4'h6);
    wait_window(WIN);
`ifdef KEYPAD_BOUNCE_EN
    n_tests++;
    if (win_toggles < 1) begin
      n_fail++;
      $display("FAIL press_bounce: col toggles=%0d, required at least 1", win_toggles);
    end
`endif
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL press: scoreboard empty, required one entry");
    end else begin
      e = sb.pop_front();
      if (held !== e.held || busy !== 1'b0 || col !== model_col(e.held, e.key, r_sel)) begin
        n_fail++;
        $display("FAIL press: held=%b busy=%b col=%b, required held=%b busy=0 col=%b",
                 held, busy, col, e.held, model_col(e.held, e.key, r_sel));
      end
    end
  endtask

  task automatic test_rows();
    logic [3:0] rs_tab[6] = '{4'b1110, 4'b1011, 4'b0111, 4'b0000, 4'b1111, 4'b1101};
    for (int i = 0; i < 6; i++) begin
      r_sel = rs_tab[i];
      #1;
      n_tests++;
      if (col !== model_col(1'b1, m_key, r_sel)) begin
        n_fail++;
        $display("FAIL rows: r_sel=%b col=%b, required %b", r_sel, col,
                 model_col(1'b1, m_key, r_sel));
      end
    end
  endtask

  task automatic test_ignore_in_held();
    issue(1'b1, 1'b0, 4'hF);
    r_sel = 4'b0111;
    #1;
    n_tests++;
    if (held !== 1'b1 || col !== 4'hF) begin
      n_fail++;
      $display("FAIL ignore_held: held=%b col=%b (row3), required held=1 col=1111", held, col);
    end
    r_sel = 4'b1101;
    #1;
    n_tests++;
    if (col !== 4'b1011) begin
      n_fail++;
      $display("FAIL ignore_held_key: col=%b (row1), required 1011", col);
    end
  endtask

  task automatic test_release();
    exp_t e;
    r_sel = 4'b1101;
    issue(1'b0, 1'b1, 4'h0);
    wait_window(WIN);
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL release: scoreboard empty, required one entry");
    end else begin
      e = sb.pop_front();
      if (held !== e.held || busy !== 1'b0 || col !== model_col(e.held, e.key, r_sel)) begin
        n_fail++;
        $display("FAIL release: held=%b busy=%b col=%b, required held=%b busy=0 col=%b",
                 held, busy, col, e.held, model_col(e.held, e.key, r_sel));
      end
    end
  endtask

  task automatic test_release_in_idle();
    r_sel = 4'b0000;
    issue(1'b0, 1'b1, 4'h0);
    tick();
    n_tests++;
    if (held !== 1'b0 || busy !== 1'b0 || col !== 4'hF) begin
      n_fail++;
      $display("FAIL release_idle: held=%b busy=%b col=%b, required 0 0 1111", held, busy, col);
    end
  endtask

  task automatic test_press_during_bounce();
    exp_t e;
    r_sel = 4'b1101;
    issue(1'b1, 1'b0, 4'h6);
    issue(1'b1, 1'b0, 4'hF);
    wait_window((WIN > 0) ? WIN - 1 : 0);
    n_tests++;
    if (sb.size() != 1) begin
      n_fail++;
      $display("FAIL drop_req: scoreboard size=%0d, required 1", sb.size());
    end else begin
      e = sb.pop_front();
      if (held !== 1'b1 || busy !== 1'b0 || col !== model_col(1'b1, e.key, r_sel)) begin
        n_fail++;
        $display("FAIL drop_req: held=%b busy=%b col=%b, required held=1 busy=0 col=%b",
                 held, busy, col, model_col(1'b1, e.key, r_sel));
      end
    end
    r_sel = 4'b0111;
    #1;
    n_tests++;
    if (col !== 4'hF) begin
      n_fail++;
      $display("FAIL drop_req_key: col=%b (row3), required 1111", col);
    end
  endtask

  task automatic test_same_cycle();
    exp_t e;
    r_sel = 4'b1011;
    issue(1'b1, 1'b1, 4'h9);
    wait_window(WIN);
    e = sb.pop_front();
    n_tests++;
    if (held !== 1'b1 || e.held !== 1'b1 || col !== 4'b1101) begin
      n_fail++;
      $display("FAIL same_idle: held=%b col=%b, required held=1 col=1101", held, col);
    end
    issue(1'b1, 1'b1, 4'h3);
    wait_window(WIN);
    e = sb.pop_front();
    n_tests++;
    if (held !== 1'b0 || e.held !== 1'b0 || col !== 4'hF) begin
      n_fail++;
      $display("FAIL same_held: held=%b col=%b, required held=0 col=1111", held, col);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] keys[5] = '{4'h0, 4'h5, 4'hA, 4'hF, 4'hC};
    logic [3:0] k;
    exp_t       e;
    for (int i = 0; i < 5; i++) begin
      k     = keys[i];
      r_sel = ~(4'b0001 << k[3:2]);
      issue(1'b1, 1'b0, k);
      wait_window(WIN);
      e = sb.pop_front();
      n_tests++;
      if (held !== e.held || col !== ~(4'b0001 << k[1:0])) begin
        n_fail++;
        $display("FAIL b2b_press key=%h: held=%b col=%b, required held=1 col=%b",
                 k, held, col, ~(4'b0001 << k[1:0]));
      end
      issue(1'b0, 1'b1, 4'h0);
      wait_window(WIN);
      e = sb.pop_front();
      n_tests++;
      if (held !== e.held || col !== 4'hF) begin
        n_fail++;
        $display("FAIL b2b_release key=%h: held=%b col=%b, required held=0 col=1111",
                 k, held, col);
      end
    end
  endtask

  task automatic test_reset_midwindow();
    exp_t e;
    r_sel = 4'b1101;
    issue(1'b1, 1'b0, 4'h6);
    repeat (20) tick();
    #2;
    reset = 1'b0;
    #1;
    n_tests++;
    if (col !== 4'hF || busy !== 1'b0 || held !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: col=%b busy=%b held=%b, required 1111 0 0", col, busy, held);
    end
    sb.delete();
    m_st = M_IDLE;
    @(negedge clk);
    reset = 1'b1;
    tick();
    n_tests++;
    if (col !== 4'hF || held !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_pending: col=%b held=%b, required 1111 0", col, held);
    end
    issue(1'b1, 1'b0, 4'h6);
    wait_window(WIN);
    e = sb.pop_front();
    n_tests++;
    if (held !== e.held || busy !== 1'b0 || col !== 4'b1011) begin
      n_fail++;
      $display("FAIL reset_repress: held=%b busy=%b col=%b, required 1 0 1011",
               held, busy, col);
    end
  endtask

  initial begin
    test_reset();
    test_press();
    test_rows();
    test_ignore_in_held();
    test_release();
    test_release_in_idle();
    test_press_during_bounce();
    test_release();
    test_same_cycle();
    test_back_to_back();
    test_reset_midwindow();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
